// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the multi-cycle RV32 control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_OR     = 4'b0010,
    ALU_AND    = 4'b0011,
    ALU_SLL    = 4'b0100,
    ALU_SLT    = 4'b0101,
    ALU_SLTU   = 4'b0110,
    ALU_XOR    = 4'b0111,
    ALU_SRL    = 4'b1000,
    ALU_SRA    = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK
  } state_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_U = 2'b10
  } imm_sel_e;

  typedef enum logic [1:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE
  } instr_class_e;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // alt selects SUB (R-type only) or SRA for the funct3 slots that have two variants
  function automatic alu_op_e funct3_to_alu(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode/funct fields -> ALU op, operand selects, class, illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output alu_op_e      alu_op,
  output logic         alu_src_a,
  output logic         alu_src_b,
  output imm_sel_e     imm_sel,
  output logic         wb_sel,
  output instr_class_e cls,
  output logic         illegal
);

  logic f7_zero, f7_alt;
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    imm_sel   = IMM_I;
    wb_sel    = 1'b0;
    cls       = CLS_ALU;
    illegal   = 1'b0;
    case (opcode)
      OPC_R: begin
        alu_op  = funct3_to_alu(funct3, funct7[5]);
        illegal = !(f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_I: begin
        // funct7 is only meaningful for the shift-immediate forms; elsewhere it is immediate bits
        alu_op    = funct3_to_alu(funct3, (funct3 == 3'b101) && funct7[5]);
        alu_src_b = 1'b1;
        if (funct3 == 3'b001)
          illegal = !f7_zero;
        else if (funct3 == 3'b101)
          illegal = !(f7_zero || f7_alt);
      end
      OPC_LOAD: begin
        alu_src_b = 1'b1;
        wb_sel    = 1'b1;
        cls       = CLS_LOAD;
      end
      OPC_STORE: begin
        alu_src_b = 1'b1;
        imm_sel   = IMM_S;
        cls       = CLS_STORE;
      end
      OPC_LUI: begin
        alu_op    = ALU_PASS_B;
        alu_src_b = 1'b1;
        imm_sel   = IMM_U;
      end
      OPC_AUIPC: begin
        alu_src_a = 1'b1;
        alu_src_b = 1'b1;
        imm_sel   = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM for the RV32 R/I/S/U datapath.
// Optional performance counters are enabled with `define MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            instr_req,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr,
  output logic            ir_we,
  output logic            pc_we,
  output logic [3:0]      alu_op,
  output logic            alu_src_a,
  output logic            alu_src_b,
  output logic [1:0]      imm_sel,
  output logic            reg_we,
  output logic            wb_sel,
  output logic            mem_re,
  output logic            mem_we,
  input  logic            mem_ready,
  output logic            illegal_instr,
  output logic            busy
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
`endif
);

  localparam state_e RESET_STATE = (RESET_STATE_FETCH != 0) ? FETCH : IDLE;

  state_e       state_reg, state_next;
  logic [16:0]  instr_reg;
  alu_op_e      alu_op_reg;
  logic         src_a_reg, src_b_reg, wb_sel_reg;
  imm_sel_e     imm_sel_reg;
  instr_class_e cls_reg;

  alu_op_e      dec_alu_op;
  logic         dec_src_a, dec_src_b, dec_wb_sel, dec_illegal;
  imm_sel_e     dec_imm_sel;
  instr_class_e dec_cls;

  logic instr_req_c, ir_we_c, pc_we_c, reg_we_c, mem_re_c, mem_we_c, illegal_c, retire_c;
  logic unused_instr;

  // Only funct7/funct3/opcode are needed for control; operand fields go straight to the datapath
  assign unused_instr = ^instr[24:7];

  ctrl_decode u_decode (
    .opcode    (instr_reg[6:0]),
    .funct3    (instr_reg[9:7]),
    .funct7    (instr_reg[16:10]),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_src_a),
    .alu_src_b (dec_src_b),
    .imm_sel   (dec_imm_sel),
    .wb_sel    (dec_wb_sel),
    .cls       (dec_cls),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= RESET_STATE;
      instr_reg   <= '0;
      alu_op_reg  <= ALU_ADD;
      src_a_reg   <= 1'b0;
      src_b_reg   <= 1'b0;
      imm_sel_reg <= IMM_I;
      wb_sel_reg  <= 1'b0;
      cls_reg     <= CLS_ALU;
    end else begin
      state_reg <= state_next;
      if (ir_we_c)
        instr_reg <= {instr[31:25], instr[14:12], instr[6:0]};
      if (state_reg == DECODE && !dec_illegal) begin
        alu_op_reg  <= dec_alu_op;
        src_a_reg   <= dec_src_a;
        src_b_reg   <= dec_src_b;
        imm_sel_reg <= dec_imm_sel;
        wb_sel_reg  <= dec_wb_sel;
        cls_reg     <= dec_cls;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    instr_req_c = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    reg_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_we_c    = 1'b0;
    illegal_c   = 1'b0;
    retire_c    = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = FETCH;
      FETCH: begin
        instr_req_c = 1'b1;
        if (instr_valid) begin
          ir_we_c    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (dec_illegal) begin
          illegal_c  = 1'b1;
          pc_we_c    = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = EXECUTE;
        end
      end
      EXECUTE: state_next = (cls_reg == CLS_ALU) ? WRITEBACK : MEM;
      MEM: begin
        mem_re_c = (cls_reg == CLS_LOAD);
        mem_we_c = (cls_reg != CLS_LOAD);
        if (mem_ready) begin
          if (cls_reg == CLS_LOAD) begin
            state_next = WRITEBACK;
          end else begin
            pc_we_c    = 1'b1;
            retire_c   = 1'b1;
            state_next = FETCH;
          end
        end
      end
      WRITEBACK: begin
        reg_we_c   = 1'b1;
        pc_we_c    = 1'b1;
        retire_c   = 1'b1;
        state_next = FETCH;
      end
      default: state_next = RESET_STATE;
    endcase
  end

  // Strobes are forced low while rst_n is asserted so nothing leaks out during reset
  assign instr_req     = instr_req_c & rst_n;
  assign ir_we         = ir_we_c & rst_n;
  assign pc_we         = pc_we_c & rst_n;
  assign reg_we        = reg_we_c & rst_n;
  assign mem_re        = mem_re_c & rst_n;
  assign mem_we        = mem_we_c & rst_n;
  assign illegal_instr = illegal_c & rst_n;
  assign busy          = (state_reg != IDLE) & rst_n;

  assign alu_op    = alu_op_reg;
  assign alu_src_a = src_a_reg;
  assign alu_src_b = src_b_reg;
  assign imm_sel   = imm_sel_reg;
  assign wb_sel    = wb_sel_reg;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [63:0] cycle_cnt_reg, instret_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      if (state_reg != IDLE) cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
      if (retire_c) instret_cnt_reg <= instret_cnt_reg + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`else
  logic unused_retire;
  assign unused_retire = retire_c;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: per-cycle strobe and datapath-control checks.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, instr_valid, mem_ready;
  logic [31:0] instr;
  logic        instr_req, ir_we, pc_we, alu_src_a, alu_src_b, reg_we, wb_sel;
  logic        mem_re, mem_we, illegal_instr, busy;
  logic [3:0]  alu_op;
  logic [1:0]  imm_sel;

  int n_tests = 0;
  int n_fail  = 0;

  // {instr_req, ir_we, pc_we, reg_we, mem_re, mem_we, illegal_instr}
  logic [6:0] strb;
  // {alu_op, alu_src_a, alu_src_b, imm_sel, wb_sel}
  logic [8:0] dp;
  assign strb = {instr_req, ir_we, pc_we, reg_we, mem_re, mem_we, illegal_instr};
  assign dp   = {alu_op, alu_src_a, alu_src_b, imm_sel, wb_sel};

  always #5 clk = ~clk;

  multicycle_ctrl #(.XLEN(32), .RESET_STATE_FETCH(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .instr_req     (instr_req),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_sel       (imm_sel),
    .reg_we        (reg_we),
    .wb_sel        (wb_sel),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .mem_ready     (mem_ready),
    .illegal_instr (illegal_instr),
    .busy          (busy)
  );

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task cyc;
    @(posedge clk);
    #1;
  endtask

  task smp;
    @(negedge clk);
  endtask

  task test_reset;
    rst_n = 1'b0; start = 1'b0; instr_valid = 1'b1; instr = 32'h40208033; mem_ready = 1'b1;
    cyc; cyc; smp;
    n_tests++;
    if (strb !== 7'b0000000) begin n_fail++; $display("FAIL reset_strobes: got %b want %b", strb, 7'b0000000); end
    n_tests++;
    if (dp !== 9'b0) begin n_fail++; $display("FAIL reset_dp: got %b want %b", dp, 9'b0); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want %b", busy, 1'b0); end
    cyc; rst_n = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; smp;
    n_tests++;
    if (strb !== 7'b1000000) begin n_fail++; $display("FAIL reset_fetch: got %b want %b", strb, 7'b1000000); end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_after: got %b want %b", busy, 1'b1); end
    $display("[TB] txn reset released, state FETCH");
  endtask

  task test_r_sub;
    cyc; instr = 32'h40208033; instr_valid = 1'b1; smp;
    n_tests++;
    if (strb !== 7'b1100000) begin n_fail++; $display("FAIL sub_c1: got %b want %b", strb, 7'b1100000); end
    cyc; smp;  // instr_valid still high in DECODE must be ignored
    n_tests++;
    if (strb !== 7'b0000000) begin n_fail++; $display("FAIL sub_c2: got %b want %b", strb, 7'b0000000); end
    cyc; instr_valid = 1'b0; smp;
    n_tests++;
    if (dp !== 9'b0001_0_0_00_0) begin n_fail++; $display("FAIL sub_c3_dp: got %b want %b", dp, 9'b0001_0_0_00_0); end
    cyc; smp;
    n_tests++;
    if (strb !== 7'b0011000) begin n_fail++; $display("FAIL sub_c4: got %b want %b", strb, 7'b0011000); end
    cyc; smp;
    n_tests++;
    if (strb !== 7'b1000000) begin n_fail++; $display("FAIL sub_c5: got %b want %b", strb, 7'b1000000); end
    n_tests++;
    if (dp !== 9'b0001_0_0_00_0) begin n_fail++; $display("FAIL sub_c5_dp_hold: got %b want %b", dp, 9'b0001_0_0_00_0); end
    $display("[TB] txn SUB 0x40208033 retired in 4 cycles");
  endtask

  task test_imm_alu;
    logic [31:0] words [4];
    logic [8:0]  exp_dp [4];
    words[0] = 32'h4030D093; exp_dp[0] = 9'b1001_0_1_00_0;  // SRAI
    words[1] = 32'h0030D093; exp_dp[1] = 9'b1000_0_1_00_0;  // SRLI
    words[2] = 32'h123450B7; exp_dp[2] = 9'b1010_0_1_10_0;  // LUI
    words[3] = 32'h00001097; exp_dp[3] = 9'b0000_1_1_10_0;  // AUIPC
    for (int k = 0; k < 4; k++) begin
      cyc; instr = words[k]; instr_valid = 1'b1; smp;
      cyc; instr_valid = 1'b0; smp;
      cyc; smp;
      n_tests++;
      if (dp !== exp_dp[k]) begin n_fail++; $display("FAIL imm_alu%0d_dp: got %b want %b", k, dp, exp_dp[k]); end
      cyc; smp;
      n_tests++;
      if (strb !== 7'b0011000) begin n_fail++; $display("FAIL imm_alu%0d_wb: got %b want %b", k, strb, 7'b0011000); end
      cyc; smp;
      n_tests++;
      if (strb !== 7'b1000000) begin n_fail++; $display("FAIL imm_alu%0d_fetch: got %b want %b", k, strb, 7'b1000000); end
      $display("[TB] txn %h alu_op=%b imm_sel=%b", words[k], alu_op, imm_sel);
    end
  endtask

  task test_load;
    cyc; instr = 32'h0000A103; instr_valid = 1'b1; smp;
    cyc; instr_valid = 1'b0; smp;
    cyc; smp;
    n_tests++;
    if (dp !== 9'b0000_0_1_00_1) begin n_fail++; $display("FAIL load_dp: got %b want %b", dp, 9'b0000_0_1_00_1); end
    for (int w = 0; w < 4; w++) begin
      cyc; mem_ready = (w == 3); smp;
      n_tests++;
      if (strb !== 7'b0000100) begin n_fail++; $display("FAIL load_mem_w%0d: got %b want %b", w, strb, 7'b0000100); end
    end
    cyc; mem_ready = 1'b0; smp;
    n_tests++;
    if (strb !== 7'b0011000) begin n_fail++; $display("FAIL load_wb: got %b want %b", strb, 7'b0011000); end
    n_tests++;
    if (wb_sel !== 1'b1) begin n_fail++; $display("FAIL load_wb_sel: got %b want %b", wb_sel, 1'b1); end
    cyc; smp;
    n_tests++;
    if (strb !== 7'b1000000) begin n_fail++; $display("FAIL load_fetch: got %b want %b", strb, 7'b1000000); end
    $display("[TB] txn LW 0x0000A103 with 3 wait states");
  endtask

  task test_store;
    cyc; instr = 32'h0020A023; instr_valid = 1'b1; smp;
    cyc; instr_valid = 1'b0; smp;
    cyc; smp;
    n_tests++;
    if (dp !== 9'b0000_0_1_01_0) begin n_fail++; $display("FAIL store_dp: got %b want %b", dp, 9'b0000_0_1_01_0); end
    cyc; smp;
    n_tests++;
    if (strb !== 7'b0000010) begin n_fail++; $display("FAIL store_wait: got %b want %b", strb, 7'b0000010); end
    cyc; mem_ready = 1'b1; smp;
    n_tests++;
    if (strb !== 7'b0010010) begin n_fail++; $display("FAIL store_done: got %b want %b", strb, 7'b0010010); end
    cyc; mem_ready = 1'b0; smp;
    n_tests++;
    if (strb !== 7'b1000000) begin n_fail++; $display("FAIL store_fetch: got %b want %b", strb, 7'b1000000); end
    $display("[TB] txn SW 0x0020A023 with 1 wait state");
  endtask

  task test_illegal;
    logic [31:0] words [2];
    words[0] = 32'h0000007F;  // unknown opcode
    words[1] = 32'h02208033;  // R-type with funct7=0000001
    for (int k = 0; k < 2; k++) begin
      cyc; instr = words[k]; instr_valid = 1'b1; smp;
      cyc; instr_valid = 1'b0; smp;
      n_tests++;
      if (strb !== 7'b0010001) begin n_fail++; $display("FAIL illegal%0d_decode: got %b want %b", k, strb, 7'b0010001); end
      cyc; smp;
      n_tests++;
      if (strb !== 7'b1000000) begin n_fail++; $display("FAIL illegal%0d_fetch: got %b want %b", k, strb, 7'b1000000); end
      $display("[TB] txn illegal %h", words[k]);
    end
  endtask

  task test_reset_in_mem;
    cyc; instr = 32'h0020A023; instr_valid = 1'b1; smp;
    cyc; instr_valid = 1'b0; smp;
    cyc; smp;
    cyc; smp;
    n_tests++;
    if (strb !== 7'b0000010) begin n_fail++; $display("FAIL rstmem_pre: got %b want %b", strb, 7'b0000010); end
    cyc; rst_n = 1'b0; mem_ready = 1'b1; smp;
    cyc; rst_n = 1'b1; smp;
    n_tests++;
    if (strb !== 7'b1000000) begin n_fail++; $display("FAIL rstmem_fetch: got %b want %b", strb, 7'b1000000); end
    n_tests++;
    if (dp !== 9'b0) begin n_fail++; $display("FAIL rstmem_dp: got %b want %b", dp, 9'b0); end
    cyc; mem_ready = 1'b0; smp;
    n_tests++;
    if (strb !== 7'b1000000) begin n_fail++; $display("FAIL rstmem_idle_fetch: got %b want %b", strb, 7'b1000000); end
    $display("[TB] txn reset during store MEM abandoned");
  endtask

  initial begin
    test_reset;
    test_r_sub;
    test_imm_alu;
    test_load;
    test_store;
    test_illegal;
    test_reset_in_mem;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the RV32 R/I/S/U datapath.
- Produces the 4-bit ALU operation code and the datapath control strobes that the ALU and register file consume.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK with valid/ready handshakes to instruction and data memory.
- Replaces the single-cycle combinational control path when the core runs in multi-cycle mode.

Parameters:
- XLEN, 32, instruction/data width
- RESET_STATE_FETCH, 1, 1: leave reset in FETCH; 0: leave reset in IDLE and wait for `start`

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  leaves IDLE (only used when RESET_STATE_FETCH=0)
- instr_req  out  1  fetch request to instruction memory
- instr_valid  in  1  instruction word valid
- instr  in  XLEN  fetched instruction
- ir_we  out  1  instruction register load strobe
- pc_we  out  1  PC <- next PC strobe
- alu_op  out  4  operation code to ALU
- alu_src_a  out  1  0=rs1, 1=PC
- alu_src_b  out  1  0=rs2, 1=immediate
- imm_sel  out  2  00=I, 01=S, 10=U
- reg_we  out  1  register file write enable
- wb_sel  out  1  0=ALU result, 1=load data
- mem_re  out  1  data read request
- mem_we  out  1  data write request
- mem_ready  in  1  data access complete
- illegal_instr  out  1  one-cycle pulse on unsupported opcode/funct
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n low at clk edge):
  - state <- FETCH (or IDLE), all outputs 0, alu_op=4'b0000.
  - Reset mid-instruction abandons it; no reg_we, pc_we or mem_we is issued after reset.
- alu_op encoding:
  - ADD 0000, SUB 0001, OR 0010, AND 0011, SLL 0100, SLT 0101, SLTU 0110, XOR 0111, SRL 1000, SRA 1001, PASS_B 1010.
  - Codes 1011–1111 are never driven.
- FETCH:
  - instr_req=1 until instr_valid is sampled high.
  - That cycle: ir_we=1, latch instr internally, go to DECODE.
- DECODE:
  - Register alu_op, alu_src_a/b, imm_sel, wb_sel and class.
  - These outputs stay stable from EXECUTE until the next DECODE.
- Decode table:
  - 0110011 (R): funct3 with funct7[5]. 000/0 ADD, 000/1 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101/0 SRL, 101/1 SRA, 110 OR, 111 AND. Any other funct7 is illegal.
  - 0010011 (I-ALU): same funct3 map with src_b=imm, imm_sel=I. No SUB. SRAI when funct7[5]=1.
  - 0000011 (load): ADD, src_b=imm, imm_sel=I, wb_sel=1.
  - 0100011 (store): ADD, src_b=imm, imm_sel=S.
  - 0110111 (LUI): PASS_B, imm_sel=U.
  - 0010111 (AUIPC): ADD, src_a=PC, src_b=imm, imm_sel=U.
- Illegal opcode/funct:
  - In DECODE, pulse illegal_instr and pc_we, then go to FETCH.
  - No reg_we, no memory strobes.
- EXECUTE: one cycle, then load/store -> MEM, others -> WRITEBACK.
- MEM:
  - Hold mem_re (load) or mem_we (store) until mem_ready is sampled high.
  - Load -> WRITEBACK.
  - Store: pulse pc_we in the mem_ready cycle, then go to FETCH.
- WRITEBACK: reg_we=1 and pc_we=1 for exactly one cycle, then FETCH.
- Latency with zero wait states:
  - ALU/LUI/AUIPC: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Strobe rules:
  - reg_we, pc_we, ir_we and illegal_instr are single-cycle pulses per instruction.
  - mem_re and mem_we are never high together.
- instr_valid outside FETCH and mem_ready outside MEM are ignored.

Optional Feature:
- Macro MULTICYCLE_CTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt[63:0] and instret_cnt[63:0], both reset to 0.
  - cycle_cnt increments every cycle while busy.
  - instret_cnt increments on each WRITEBACK and each store completion. Illegal instructions are not counted.
  - Both counters wrap modulo 2^64.
- When undefined: no counter ports or logic.

Decomposition:
- Package ctrl_pkg holds:
  - alu_op_e enum with the encoding above.
  - Opcode constants.
  - state_e enum {IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK}.
  - imm_sel_e.
- One sub-module, ctrl_decode: combinational instr -> {alu_op, src selects, imm_sel, class, illegal}.
- The FSM lives in multicycle_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with instr_valid=1 -> all strobes 0, state FETCH, alu_op=0000.
- R-type SUB, instr 0x40208033, instr_valid immediately -> ir_we at cycle 1, alu_op=0001 from cycle 3, reg_we and pc_we pulse at cycle 4.
- SRAI 0x4030D093 -> alu_op=1001, alu_src_b=1. SRLI 0x0030D093 -> alu_op=1000.
- Load 0x0000A103 with mem_ready delayed 3 cycles -> mem_re held 4 cycles, wb_sel=1, reg_we one cycle after mem_ready.
- LUI 0x123450B7 -> alu_op=1010, imm_sel=10. Store 0x0020A023 -> mem_we until mem_ready, reg_we never asserted.
- Illegal opcode 0x0000007F -> illegal_instr and pc_we pulse in DECODE, no reg_we or mem strobes. rst_n low during MEM -> mem_we drops next cycle, state FETCH.
